// File: rtl/mul4_pkg.sv
// mul4_pkg -- shared definitions for the sequential 4x4 unsigned multiplier.
//   W       : operand width
//   NSTEPS  : number of shift-add steps per multiply
//   STEP_W  : width of the step counter
//   state_t : FSM state encoding (IDLE, RUN, DONE)
package mul4_pkg;

  localparam int W      = 4;
  localparam int NSTEPS = 4;
  localparam int STEP_W = $clog2(NSTEPS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul4_seq_cpa.sv
// CPA -- W-bit carry-propagate adder.
//   a, b  : addends
//   c_in  : carry in
//   sum   : W-bit sum
//   c_out : carry out
module CPA
  import mul4_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic [W-1:0] sum,
  output logic         c_out
);

  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c_in};

endmodule

// File: rtl/mul4_seq.sv
// mul4_seq -- sequential 4x4 unsigned shift-add multiplier.
// One shift-add step per clock; product valid 4 edges after acceptance.
//   clk   : clock, rising edge active
//   reset : asynchronous, active-high; clears FSM and datapath
//   start : multiply request, only sampled in IDLE
//   a, b  : unsigned operands, captured on the accepting edge
//   busy  : high in RUN and DONE
//   done  : one-cycle pulse, p newly valid
//   p     : registered product, held until the next completion
module mul4_seq
  import mul4_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [2*W-1:0] p
);

  state_t              state;
  state_t              state_nxt;
  logic [W-1:0]        m;
  logic [W-1:0]        q;
  logic [W-1:0]        acc;
  logic [W-1:0]        addend;
  logic [W-1:0]        sum;
  logic                c;
  logic [STEP_W-1:0]   step;
  logic                last_step;

  assign last_step = (step == STEP_W'(NSTEPS - 1));
  assign addend    = q[0] ? m : '0;

  CPA u_cpa (
    .a     (acc),
    .b     (addend),
    .c_in  (1'b0),
    .sum   (sum),
    .c_out (c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m    <= '0;
      q    <= '0;
      acc  <= '0;
      step <= '0;
      p    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m    <= a;
            q    <= b;
            acc  <= '0;
            step <= '0;
          end
        end
        RUN: begin
          // Shift {c,sum,q} right by one: carry is kept in the accumulator MSB,
          // sum LSB moves into the multiplier register as a product bit.
          acc  <= {c, sum[W-1:1]};
          q    <= {sum[0], q[W-1:1]};
          step <= step + STEP_W'(1);
          if (last_step) p <= {c, sum, q[W-1:1]};
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_mul4_seq.sv
module tb_mul4_seq;
  import mul4_pkg::*;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] p;

  int n_checks;
  int n_fail;

  mul4_seq dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Issue one start pulse, then observe the 8 sample points after edges E0..E7.
  // lat = index of the first sample with done high (0 if never),
  // pr = p at that sample, pchg = p moved before done.
  task automatic do_mul(input logic [3:0] ta, input logic [3:0] tb_v,
                        output int lat, output logic [7:0] pr,
                        output int nbusy, output int ndone, output bit pchg);
    logic [7:0] p0;
    lat = 0; nbusy = 0; ndone = 0; pchg = 1'b0;
    @(negedge clk);
    a = ta; b = tb_v; start = 1'b1;
    p0 = p;
    pr = p;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (lat == 0) begin
          lat = i;
          pr  = p;
        end
      end else if (lat == 0 && p !== p0) begin
        pchg = 1'b1;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; a = 4'd3; b = 4'd3;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || p !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b p=%h, required 0 0 00", busy, done, p);
    end
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || dut.state !== IDLE) begin
      n_fail++;
      $display("FAIL reset_no_accept: busy=%b state=%0d, required busy=0 IDLE", busy, dut.state);
    end
    n_checks++;
    if (dut.m !== 4'h0 || dut.q !== 4'h0 || dut.acc !== 4'h0 || dut.step !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_regs: m=%h q=%h acc=%h step=%0d, required all 0",
               dut.m, dut.q, dut.acc, dut.step);
    end
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_carry;
    int lat, nbusy, ndone; logic [7:0] pr; bit pchg;
    do_mul(4'hF, 4'hF, lat, pr, nbusy, ndone, pchg);
    n_checks++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL carry_latency: got %0d, required 4", lat);
    end
    n_checks++;
    if (pr !== 8'hE1) begin
      n_fail++;
      $display("FAIL carry_product: got %h, required e1", pr);
    end
    n_checks++;
    if (nbusy !== 5) begin
      n_fail++;
      $display("FAIL carry_busy_cycles: got %0d, required 5", nbusy);
    end
    n_checks++;
    if (ndone !== 1) begin
      n_fail++;
      $display("FAIL carry_done_pulses: got %0d, required 1", ndone);
    end
    n_checks++;
    if (p !== 8'hE1) begin
      n_fail++;
      $display("FAIL carry_p_hold: got %h, required e1", p);
    end
  endtask

  task automatic test_mixed;
    int lat, nbusy, ndone; logic [7:0] pr; bit pchg;
    do_mul(4'hA, 4'h5, lat, pr, nbusy, ndone, pchg);
    n_checks++;
    if (pr !== 8'h32 || lat !== 4) begin
      n_fail++;
      $display("FAIL mixed_a5: got p=%h lat=%0d, required p=32 lat=4", pr, lat);
    end
    do_mul(4'h0, 4'h9, lat, pr, nbusy, ndone, pchg);
    n_checks++;
    if (pr !== 8'h00 || lat !== 4) begin
      n_fail++;
      $display("FAIL mixed_zero: got p=%h lat=%0d, required p=00 lat=4", pr, lat);
    end
    n_checks++;
    if (pchg !== 1'b0) begin
      n_fail++;
      $display("FAIL p_stable_in_run: got changed=%b, required 0", pchg);
    end
    do_mul(4'h9, 4'h0, lat, pr, nbusy, ndone, pchg);
    n_checks++;
    if (pr !== 8'h00 || lat !== 4 || nbusy !== 5) begin
      n_fail++;
      $display("FAIL mixed_b_zero: got p=%h lat=%0d busy=%0d, required 00 4 5", pr, lat, nbusy);
    end
  endtask

  task automatic test_start_busy;
    int ndone;
    ndone = 0;
    @(negedge clk);
    a = 4'd3; b = 4'd4; start = 1'b1;
    @(posedge clk); #1;                 // E0
    start = 1'b0;
    @(posedge clk); #1;                 // E1
    if (done) ndone++;
    @(negedge clk);
    a = 4'd7; b = 4'd7; start = 1'b1;
    @(posedge clk); #1;                 // E2
    start = 1'b0;
    if (done) ndone++;
    @(posedge clk); #1;                 // E3
    if (done) ndone++;
    @(posedge clk); #1;                 // E4
    if (done) ndone++;
    n_checks++;
    if (done !== 1'b1 || p !== 8'h0C) begin
      n_fail++;
      $display("FAIL busy_ignore_result: done=%b p=%h, required 1 0c", done, p);
    end
    n_checks++;
    if (dut.m !== 4'd3) begin
      n_fail++;
      $display("FAIL busy_ignore_m: got %h, required 3", dut.m);
    end
    @(negedge clk);
    a = 4'd7; b = 4'd7; start = 1'b1;   // during DONE
    @(posedge clk); #1;                 // E5
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_cycle_ignore: busy=%b done=%b, required 0 0", busy, done);
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    n_checks++;
    if (ndone !== 1 || p !== 8'h0C) begin
      n_fail++;
      $display("FAIL busy_single_done: got dones=%0d p=%h, required 1 0c", ndone, p);
    end
  endtask

  task automatic test_reset_mid;
    int ndone, lat, nbusy; logic [7:0] pr; bit pchg;
    ndone = 0;
    @(negedge clk);
    a = 4'hF; b = 4'hF; start = 1'b1;
    @(posedge clk); #1;                 // E0
    start = 1'b0;
    @(posedge clk); #1;                 // E1
    @(posedge clk); #1;                 // E2
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || p !== 8'h00 || dut.state !== IDLE) begin
      n_fail++;
      $display("FAIL reset_mid_async: busy=%b done=%b p=%h state=%0d, required 0 0 00 IDLE",
               busy, done, p, dut.state);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    n_checks++;
    if (ndone !== 0 || p !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid_no_done: got dones=%0d p=%h, required 0 00", ndone, p);
    end
    do_mul(4'd6, 4'd7, lat, pr, nbusy, ndone, pchg);
    n_checks++;
    if (pr !== 8'h2A || lat !== 4) begin
      n_fail++;
      $display("FAIL reset_mid_recover: got p=%h lat=%0d, required 2a 4", pr, lat);
    end
  endtask

  task automatic test_start_held;
    int first_done, last_done, ndone, bad_iv, bad_p;
    first_done = 0; last_done = 0; ndone = 0; bad_iv = 0; bad_p = 0;
    @(negedge clk);
    a = 4'd2; b = 4'd3; start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (p !== 8'h06) bad_p++;
        if (first_done == 0) first_done = i;
        else if (i - last_done != 6) bad_iv++;
        last_done = i;
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    n_checks++;
    if (ndone !== 3 || first_done !== 5) begin
      n_fail++;
      $display("FAIL held_done_count: got %0d first=%0d, required 3 first=5", ndone, first_done);
    end
    n_checks++;
    if (bad_iv !== 0 || bad_p !== 0) begin
      n_fail++;
      $display("FAIL held_interval: bad intervals=%0d bad p=%0d, required 0 0", bad_iv, bad_p);
    end
  endtask

  task automatic test_exhaustive;
    int lat, nbusy, ndone; logic [7:0] pr, expv; bit pchg;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        expv = 8'(i * j);
        do_mul(4'(i), 4'(j), lat, pr, nbusy, ndone, pchg);
        n_checks++;
        if (pr !== expv || lat !== 4) begin
          n_fail++;
          $display("FAIL exhaustive %0d*%0d: got p=%h lat=%0d, required %h 4", i, j, pr, lat, expv);
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    start = 1'b0; a = '0; b = '0; reset = 1'b1;
    test_reset;
    test_carry;
    test_mixed;
    test_start_busy;
    test_reset_mid;
    test_start_held;
    test_exhaustive;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
